// File: rtl/alu_seq_issuer.sv
// rtl/alu_seq_issuer.sv - request/response sequencer driving a 3-bit-opcode combinational ALU
// Synthesizes SLL, signed SLT and SRA as multi-pass sequences; optional counters under ALU_SEQ_PERF_EN.
module alu_seq_issuer #(
  parameter logic [2:0] IDLE_OP = 3'b000,
  parameter int         SHAMT_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_res,
  output logic        rsp_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic        alu_zero
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0] perf_passes,
  output logic [15:0] perf_zero_hits
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;
  localparam logic [31:0] SIGN_BIT = 32'h8000_0000;

  state_t               r_state, w_state_nxt;
  logic [3:0]           r_op;
  logic [31:0]          r_acc, r_tmp;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [1:0]           r_step;
  logic                 r_neg;
  logic [31:0]          r_rsp_res;
  logic                 r_rsp_zero;

  logic [31:0]          w_alu_a, w_alu_b, w_shamt, w_res_cap;
  logic [2:0]           w_alu_op;
  logic                 w_last, w_acc_wr, w_tmp_wr, w_cnt_dec, w_force_zero;
  logic                 w_unused;

  assign w_shamt = {{(32-SHAMT_W){1'b0}}, r_tmp[SHAMT_W-1:0]};
  assign w_unused = alu_zero;

  // Pass decode: what the ALU sees this cycle and where its result goes at the edge.
  always_comb begin
    w_alu_a      = 32'd0;
    w_alu_b      = 32'd0;
    w_alu_op     = IDLE_OP;
    w_last       = 1'b0;
    w_acc_wr     = 1'b0;
    w_tmp_wr     = 1'b0;
    w_cnt_dec    = 1'b0;
    w_force_zero = 1'b0;
    if (r_state == S_EXEC) begin
      w_last  = 1'b1;
      w_alu_a = r_acc;
      w_alu_b = r_tmp;
      case (r_op)
        4'd0: w_alu_op = OP_ADD;
        4'd1: w_alu_op = OP_SUB;
        4'd2: w_alu_op = OP_AND;
        4'd3: w_alu_op = OP_OR;
        4'd4: w_alu_op = OP_XOR;
        4'd5: w_alu_op = OP_NOR;
        4'd6: w_alu_op = OP_SRL;
        4'd7: w_alu_op = OP_SLTU;
        4'd8: begin
          if (r_cnt == '0) begin
            w_alu_op = OP_OR;
            w_alu_b  = 32'd0;
          end else begin
            w_alu_op  = OP_ADD;
            w_alu_b   = r_acc;
            w_acc_wr  = 1'b1;
            w_cnt_dec = 1'b1;
            w_last    = (r_cnt == SHAMT_W'(1));
          end
        end
        4'd9: begin
          case (r_step)
            2'd0: begin
              w_alu_op = OP_XOR;
              w_alu_b  = SIGN_BIT;
              w_acc_wr = 1'b1;
              w_last   = 1'b0;
            end
            2'd1: begin
              w_alu_op = OP_XOR;
              w_alu_a  = r_tmp;
              w_alu_b  = SIGN_BIT;
              w_tmp_wr = 1'b1;
              w_last   = 1'b0;
            end
            default: w_alu_op = OP_SLTU;
          endcase
        end
        4'd10: begin
          // Negative operands are shifted in complemented form so zero-fill becomes sign-fill.
          if (!r_neg) begin
            w_alu_op = OP_SRL;
            w_alu_b  = w_shamt;
          end else begin
            case (r_step)
              2'd0: begin
                w_alu_op = OP_NOR;
                w_alu_b  = r_acc;
                w_acc_wr = 1'b1;
                w_last   = 1'b0;
              end
              2'd1: begin
                w_alu_op = OP_SRL;
                w_alu_b  = w_shamt;
                w_acc_wr = 1'b1;
                w_last   = 1'b0;
              end
              default: begin
                w_alu_op = OP_NOR;
                w_alu_b  = r_acc;
              end
            endcase
          end
        end
        default: begin
          w_alu_op     = OP_AND;
          w_alu_a      = 32'd0;
          w_alu_b      = 32'd0;
          w_force_zero = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_nxt = S_EXEC;
      S_EXEC:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_res_cap = w_force_zero ? 32'd0 : alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= 4'd0;
      r_acc      <= 32'd0;
      r_tmp      <= 32'd0;
      r_cnt      <= '0;
      r_step     <= 2'd0;
      r_neg      <= 1'b0;
      r_rsp_res  <= 32'd0;
      r_rsp_zero <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && req_valid) begin
        r_op   <= req_op;
        r_acc  <= req_a;
        r_tmp  <= req_b;
        r_cnt  <= req_b[SHAMT_W-1:0];
        r_step <= 2'd0;
        r_neg  <= req_a[31];
      end else if (r_state == S_EXEC) begin
        if (w_acc_wr)  r_acc <= alu_res;
        if (w_tmp_wr)  r_tmp <= alu_res;
        if (w_cnt_dec) r_cnt <= r_cnt - SHAMT_W'(1);
        r_step <= r_step + 2'd1;
        if (w_last) begin
          r_rsp_res  <= w_res_cap;
          r_rsp_zero <= (w_res_cap == 32'd0);
        end
      end
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] r_perf_passes;
  logic [15:0] r_perf_zero_hits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_passes    <= 32'd0;
      r_perf_zero_hits <= 16'd0;
    end else if (r_state == S_EXEC) begin
      r_perf_passes <= r_perf_passes + 32'd1;
      if (alu_zero && r_perf_zero_hits != 16'hFFFF)
        r_perf_zero_hits <= r_perf_zero_hits + 16'd1;
    end
  end

  assign perf_passes    = r_perf_passes;
  assign perf_zero_hits = r_perf_zero_hits;
`endif

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_res   = r_rsp_res;
  assign rsp_zero  = r_rsp_zero;
  assign alu_a     = w_alu_a;
  assign alu_b     = w_alu_b;
  assign alu_op    = w_alu_op;

endmodule

// File: tb/tb_alu_seq_issuer.sv
// tb/tb_alu_seq_issuer.sv - scoreboard bench for alu_seq_issuer with a behavioural ALU
module tb_alu_seq_issuer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero, alu_zero;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b, rsp_res, alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_passes;
  logic [15:0] perf_zero_hits;
`endif

  always #5 clk = ~clk;

  alu_seq_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res), .alu_zero(alu_zero)
`ifdef ALU_SEQ_PERF_EN
    , .perf_passes(perf_passes), .perf_zero_hits(perf_zero_hits)
`endif
  );

  // Datapath ALU: 000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 sltu.
  always_comb begin
    case (alu_op)
      3'b000:  alu_res = alu_a & alu_b;
      3'b001:  alu_res = alu_a | alu_b;
      3'b010:  alu_res = alu_a + alu_b;
      3'b011:  alu_res = alu_a ^ alu_b;
      3'b100:  alu_res = ~(alu_a | alu_b);
      3'b101:  alu_res = alu_a >> alu_b[4:0];
      3'b110:  alu_res = alu_a - alu_b;
      default: alu_res = {31'd0, alu_a < alu_b};
    endcase
  end
  assign alu_zero = (alu_res == 32'd0);

  int errs = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] s;
    s = a;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return a >> b[4:0];
      4'd7:    return {31'd0, a < b};
      4'd8:    return a << b[4:0];
      4'd9:    return {31'd0, $signed(a) < $signed(b)};
      4'd10:   return s >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_passes(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 4'd8) return (b[4:0] == 5'd0) ? 1 : int'(b[4:0]);
    if (op == 4'd9) return 3;
    if (op == 4'd10) return a[31] ? 3 : 1;
    return 1;
  endfunction

  function automatic logic [2:0] ref_op0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return 3'b010;
      4'd1:    return 3'b110;
      4'd2:    return 3'b000;
      4'd3:    return 3'b001;
      4'd4:    return 3'b011;
      4'd5:    return 3'b100;
      4'd6:    return 3'b101;
      4'd7:    return 3'b111;
      4'd8:    return (b[4:0] == 5'd0) ? 3'b001 : 3'b010;
      4'd9:    return 3'b011;
      4'd10:   return a[31] ? 3'b100 : 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("req_ready_before_req", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    int          lat;
    logic [2:0]  op0;
    logic [31:0] e, held;
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    exp_q.push_back(ref_res(op, a, b));
    lat_q.push_back(ref_passes(op, a, b));
    @(negedge clk);
    req_valid = 1'b0;
    op0 = alu_op;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("first_alu_op", {29'd0, op0}, {29'd0, ref_op0(op, a, b)});
    check_val("latency", lat, lat_q.pop_front());
    e = exp_q.pop_front();
    check_val("rsp_res", rsp_res, e);
    check_val("rsp_zero", {31'd0, rsp_zero}, {31'd0, e == 32'd0});
    held = rsp_res;
    if (hold > 0) begin
      req_valid = 1'b1;
      req_op = 4'd0;
      req_a = 32'h1234_5678;
      req_b = 32'h1;
      repeat (hold) @(negedge clk);
      check_val("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("bp_rsp_res", rsp_res, held);
      check_val("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (hold > 0) begin
      check_val("release_req_ready", {31'd0, req_ready}, 32'd1);
      check_val("release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_op = 4'd0;
    req_a = 32'd0;
    req_b = 32'd0;
    repeat (2) @(negedge clk);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_rsp_res", rsp_res, 32'd0);
    check_val("rst_rsp_zero", {31'd0, rsp_zero}, 32'd1);
    check_val("rst_alu_op", {29'd0, alu_op}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_req_ready", {31'd0, req_ready}, 32'd1);

    run(4'd1,  32'd5,        32'd5,        0);
    run(4'd8,  32'h3,        32'h24,       0);
    run(4'd8,  32'h3,        32'h0,        0);
    run(4'd9,  32'hFFFFFFFF, 32'd1,        0);
    run(4'd7,  32'hFFFFFFFF, 32'd1,        0);
    run(4'd10, 32'h80000000, 32'd4,        0);
    run(4'd10, 32'h40000000, 32'd4,        0);
    run(4'd10, 32'h80000001, 32'hFFFFFFE1, 0);
    run(4'd0,  32'hFFFFFFFF, 32'd2,        0);
    run(4'd8,  32'h1,        32'd31,       0);
    run(4'd12, 32'hDEADBEEF, 32'h12345678, 0);
    run(4'd9,  32'd3,        32'hFFFFFFFE, 5);
    for (int i = 0; i < 12; i++)
      run(4'($urandom_range(0, 15)), $urandom, $urandom, 0);

    @(negedge clk);
    wait_ready();
    req_valid = 1'b1;
    req_op = 4'd8;
    req_a = 32'h1;
    req_b = 32'd31;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("midrst_alu_op", {29'd0, alu_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("postrst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("postrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
`ifdef ALU_SEQ_PERF_EN
    check_val("postrst_perf_passes", perf_passes, 32'd0);
`endif
    run(4'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
    check_val("sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
